// File: rtl/riscv_defs.sv
// rtl/riscv_defs.sv - shared constants and types for the data-memory arbiter
package riscv_defs;

  localparam int XLEN     = 32;
  localparam int NB_BYTE  = 8;
  localparam int MEM_SIZE = 4096;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                      we;
    logic [XLEN/NB_BYTE-1:0]   be;
    logic [XLEN-1:0]           addr;
    logic [XLEN-1:0]           wdata;
  } dmem_req_t;

endpackage

// File: rtl/riscv_arb_rr2.sv
// rtl/riscv_arb_rr2.sv - two-way round-robin grant with force overrides
module riscv_arb_rr2
  import riscv_defs::*;
(
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_req_c,
  input  logic i_req_d,
  input  logic i_force_c,
  input  logic i_force_d,
  output logic o_gnt_c,
  output logic o_gnt_d
);

  logic last_gnt_q;
  logic last_gnt_d;

  // Force C wins over force D; otherwise a tie goes to the port not granted last.
  always_comb begin
    o_gnt_c = 1'b0;
    o_gnt_d = 1'b0;
    if (i_force_c) begin
      o_gnt_c = i_req_c;
    end else if (i_force_d) begin
      o_gnt_d = i_req_d;
    end else if (i_req_c && i_req_d) begin
      if (last_gnt_q == PORT_D) o_gnt_c = 1'b1;
      else                      o_gnt_d = 1'b1;
    end else begin
      o_gnt_c = i_req_c;
      o_gnt_d = i_req_d;
    end
  end

  // Remember which port won; a fresh reset favours C on the first tie.
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (o_gnt_c)      last_gnt_d = PORT_C;
    else if (o_gnt_d) last_gnt_d = PORT_D;
  end

  // Last-grant register.
  always_ff @(posedge i_clock) begin
    if (!i_reset) last_gnt_q <= PORT_D;
    else          last_gnt_q <= last_gnt_d;
  end

endmodule

// File: rtl/riscv_dmem_arbiter.sv
// rtl/riscv_dmem_arbiter.sv - shares DMEM between core and debug ports with bounded lock
module riscv_dmem_arbiter
  import riscv_defs::*;
#(
  parameter int DATA_W   = XLEN,
  parameter int ADDR_W   = XLEN,
  parameter int MEM_SZ   = MEM_SIZE,
  parameter int MAX_LOCK = 16
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_c_req,
  input  logic                      i_c_we,
  input  logic [DATA_W/NB_BYTE-1:0] i_c_be,
  input  logic [ADDR_W-1:0]         i_c_addr,
  input  logic [DATA_W-1:0]         i_c_wdata,
  output logic                      o_c_gnt,
  output logic                      o_c_rvalid,
  output logic [DATA_W-1:0]         o_c_rdata,
  output logic                      o_c_err,
  input  logic                      i_d_req,
  input  logic                      i_d_we,
  input  logic [DATA_W/NB_BYTE-1:0] i_d_be,
  input  logic [ADDR_W-1:0]         i_d_addr,
  input  logic [DATA_W-1:0]         i_d_wdata,
  output logic                      o_d_gnt,
  output logic                      o_d_rvalid,
  output logic [DATA_W-1:0]         o_d_rdata,
  output logic                      o_d_err,
  input  logic                      i_d_lock,
  output logic                      o_mem_en,
  output logic [DATA_W/NB_BYTE-1:0] o_mem_we,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [DATA_W-1:0]         o_mem_wdata,
  input  logic [DATA_W-1:0]         i_mem_rdata
);

  localparam int NB    = DATA_W / NB_BYTE;
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

  logic resp_valid_q, resp_valid_d;
  logic resp_read_q,  resp_read_d;
  logic resp_owner_q, resp_owner_d;
  logic resp_err_q,   resp_err_d;

  logic      in_lock;
  logic      lock_full;
  logic      force_c;
  logic      force_d;
  logic      req_c;
  logic      req_d;
  logic      gnt_c;
  logic      gnt_d;
  logic      any_gnt;
  logic      in_range;
  dmem_req_t req_c_s;
  dmem_req_t req_d_s;
  dmem_req_t sel;

  // Lock only holds while debug keeps i_d_lock high; a dropped lock arbitrates normally.
  assign in_lock   = (state_q == LOCK) && i_d_lock;
  assign lock_full = (lock_cnt_q == CNT_W'(MAX_LOCK));
  assign force_c   = in_lock && lock_full;
  assign force_d   = in_lock && !lock_full;

  // Requests are masked in reset so nothing is granted and last-grant stays put.
  assign req_c = i_reset && i_c_req;
  assign req_d = i_reset && i_d_req;

  riscv_arb_rr2 u_rr (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_req_c   (req_c),
    .i_req_d   (req_d),
    .i_force_c (force_c),
    .i_force_d (force_d),
    .o_gnt_c   (gnt_c),
    .o_gnt_d   (gnt_d)
  );

  assign o_c_gnt = gnt_c;
  assign o_d_gnt = gnt_d;
  assign any_gnt = gnt_c || gnt_d;

  assign req_c_s = '{we: i_c_we, be: i_c_be, addr: i_c_addr, wdata: i_c_wdata};
  assign req_d_s = '{we: i_d_we, be: i_d_be, addr: i_d_addr, wdata: i_d_wdata};
  assign sel     = gnt_d ? req_d_s : req_c_s;

  // Out-of-range accesses are still granted but never reach DMEM.
  assign in_range    = (sel.addr < ADDR_W'(MEM_SZ));
  assign o_mem_en    = any_gnt && in_range;
  assign o_mem_we    = o_mem_en ? (sel.be & {NB{sel.we}}) : '0;
  assign o_mem_addr  = any_gnt ? sel.addr  : '0;
  assign o_mem_wdata = any_gnt ? sel.wdata : '0;

  // Next-state: lock entry on a locked D grant, bounded wait counter for C.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    if (in_lock) begin
      state_d = LOCK;
      if (gnt_c) begin
        lock_cnt_d = '0;
      end else if (i_c_req && !lock_full) begin
        lock_cnt_d = lock_cnt_q + CNT_W'(1);
      end
    end else begin
      lock_cnt_d = '0;
      state_d    = (gnt_d && i_d_lock) ? LOCK : ARB;
    end
  end

  // Response tracking: who was granted and whether a read or error is owed next cycle.
  always_comb begin
    resp_valid_d = any_gnt;
    resp_read_d  = any_gnt && !sel.we;
    resp_owner_d = gnt_d ? PORT_D : PORT_C;
    resp_err_d   = any_gnt && !in_range;
  end

  // State, counter and response registers.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q      <= ARB;
      lock_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_read_q  <= 1'b0;
      resp_owner_q <= PORT_C;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_read_q  <= resp_read_d;
      resp_owner_q <= resp_owner_d;
      resp_err_q   <= resp_err_d;
    end
  end

  logic c_hit;
  logic d_hit;

  // Gated by i_reset so a response pending at reset entry is dropped immediately.
  assign c_hit = i_reset && resp_valid_q && (resp_owner_q == PORT_C);
  assign d_hit = i_reset && resp_valid_q && (resp_owner_q == PORT_D);

  assign o_c_rvalid = c_hit && resp_read_q;
  assign o_c_err    = c_hit && resp_err_q;
  assign o_c_rdata  = (c_hit && resp_read_q && !resp_err_q) ? i_mem_rdata : '0;
  assign o_d_rvalid = d_hit && resp_read_q;
  assign o_d_err    = d_hit && resp_err_q;
  assign o_d_rdata  = (d_hit && resp_read_q && !resp_err_q) ? i_mem_rdata : '0;

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// tb/tb_riscv_dmem_arbiter.sv - self-checking bench for riscv_dmem_arbiter
module tb_riscv_dmem_arbiter;

  localparam int MSZ  = 4096;
  localparam int MAXL = 16;

  logic        clk;
  logic        rstn;
  logic        c_req, c_we, d_req, d_we, d_lock;
  logic [3:0]  c_be, d_be;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  riscv_dmem_arbiter dut (
    .i_clock(clk), .i_reset(rstn),
    .i_c_req(c_req), .i_c_we(c_we), .i_c_be(c_be), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .o_c_gnt(c_gnt), .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata), .o_c_err(c_err),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_be(d_be), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata), .o_d_err(d_err),
    .i_d_lock(d_lock),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Environment DMEM: one-cycle read latency, byte writes.
  logic [31:0] dmem [0:MSZ/4-1];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= dmem[mem_addr[11:2]];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) dmem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // Reference model state.
  logic [31:0] mm [0:MSZ/4-1];
  bit          model_on = 1'b0;
  bit          m_last_d;
  bit          m_lock;
  int          m_wait;
  bit          p_valid, p_owner_d, p_read, p_err;
  logic [31:0] p_rdata;

  always @(negedge clk) begin
    if (model_on) begin
      bit          gc, gd, we, oor, en, ilock;
      logic [3:0]  be;
      logic [31:0] addr, wd;
      logic [31:0] e_crd, e_drd;
      bit          e_crv, e_cer, e_drv, e_der;
      if (!rstn) begin
        chk("rst_c_gnt", {31'd0, c_gnt}, 0);
        chk("rst_d_gnt", {31'd0, d_gnt}, 0);
        chk("rst_mem_en", {31'd0, mem_en}, 0);
        chk("rst_mem_we", {28'd0, mem_we}, 0);
        chk("rst_rvalid", {30'd0, c_rvalid, d_rvalid}, 0);
        chk("rst_err", {30'd0, c_err, d_err}, 0);
        chk("rst_rdata", c_rdata | d_rdata, 0);
        m_last_d = 1'b1; m_lock = 1'b0; m_wait = 0;
        p_valid = 1'b0;
      end else begin
        e_crv = p_valid && !p_owner_d && p_read;
        e_cer = p_valid && !p_owner_d && p_err;
        e_drv = p_valid &&  p_owner_d && p_read;
        e_der = p_valid &&  p_owner_d && p_err;
        e_crd = (e_crv && !p_err) ? p_rdata : 32'd0;
        e_drd = (e_drv && !p_err) ? p_rdata : 32'd0;
        ilock = m_lock && d_lock;
        if (ilock) begin
          gc = (m_wait == MAXL) && c_req;
          gd = (m_wait != MAXL) && d_req;
        end else if (c_req && d_req) begin
          gc = m_last_d;
          gd = !m_last_d;
        end else begin
          gc = c_req;
          gd = d_req;
        end
        we   = gd ? d_we : c_we;
        be   = gd ? d_be : c_be;
        addr = gd ? d_addr : c_addr;
        wd   = gd ? d_wdata : c_wdata;
        oor  = addr >= MSZ;
        en   = (gc || gd) && !oor;
        chk("c_gnt", {31'd0, c_gnt}, {31'd0, gc});
        chk("d_gnt", {31'd0, d_gnt}, {31'd0, gd});
        chk("mem_en", {31'd0, mem_en}, {31'd0, en});
        chk("mem_we", {28'd0, mem_we}, (en && we) ? {28'd0, be} : 32'd0);
        if (en) begin
          chk("mem_addr", mem_addr, addr);
          chk("mem_wdata", mem_wdata, wd);
        end
        chk("c_rvalid", {31'd0, c_rvalid}, {31'd0, e_crv});
        chk("c_err", {31'd0, c_err}, {31'd0, e_cer});
        chk("c_rdata", c_rdata, e_crd);
        chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, e_drv});
        chk("d_err", {31'd0, d_err}, {31'd0, e_der});
        chk("d_rdata", d_rdata, e_drd);
        p_valid   = gc || gd;
        p_owner_d = gd;
        p_read    = !we;
        p_err     = oor;
        p_rdata   = oor ? 32'd0 : mm[addr[11:2]];
        if (en && we)
          for (int b = 0; b < 4; b++)
            if (be[b]) mm[addr[11:2]][8*b +: 8] = wd[8*b +: 8];
        if (gc) m_last_d = 1'b0;
        else if (gd) m_last_d = 1'b1;
        if (ilock) begin
          if (gc) m_wait = 0;
          else if (c_req && m_wait < MAXL) m_wait++;
        end else begin
          m_wait = 0;
          m_lock = gd && d_lock;
        end
      end
    end
  end

  task automatic obs();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    c_req = 0; c_we = 0; c_be = 4'hF; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_be = 4'hF; d_addr = 0; d_wdata = 0; d_lock = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    adv();
    adv();
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, cg_n, dg_n;
    int cg_at[$];
    for (int i = 0; i < MSZ/4; i++) begin
      dmem[i] = 32'd0;
      mm[i]   = 32'd0;
    end
    dmem[4] = 32'hDEADBEEF;
    mm[4]   = 32'hDEADBEEF;
    mem_rdata = 32'd0;
    rstn = 1'b0;
    idle();
    c_req = 1; d_req = 1;
    model_on = 1'b1;
    obs();
    chk("t0_reset_gnt", {30'd0, c_gnt, d_gnt}, 0);
    adv();
    idle();
    do_reset();

    // 1: C-only read of preloaded word.
    c_req = 1; c_addr = 32'h10;
    obs();
    chk("t1_gnt", {31'd0, c_gnt}, 1);
    adv();
    c_req = 0;
    obs();
    chk("t1_rvalid", {31'd0, c_rvalid}, 1);
    chk("t1_rdata", c_rdata, 32'hDEADBEEF);
    chk("t1_d_rvalid", {31'd0, d_rvalid}, 0);
    adv();

    // 2: both request continuously after reset; C first, then alternate.
    do_reset();
    c_req = 1; c_addr = 32'h0;
    d_req = 1; d_addr = 32'h4;
    for (int i = 0; i < 6; i++) begin
      obs();
      chk($sformatf("t2_gnt%0d", i), {30'd0, c_gnt, d_gnt}, (i % 2 == 0) ? 32'd2 : 32'd1);
      adv();
    end
    idle();
    adv();

    // 3: D partial write then read back.
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h20; d_wdata = 32'h11223344;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      obs();
      if (d_gnt) begin got = 1; break; end
      adv();
    end
    chk("t3_wgnt", got, 1);
    adv();
    d_we = 0; d_be = 4'hF;
    obs();
    chk("t3_rgnt", {31'd0, d_gnt}, 1);
    adv();
    d_req = 0;
    obs();
    chk("t3_rvalid", {31'd0, d_rvalid}, 1);
    chk("t3_rdata", d_rdata, 32'h00003344);
    adv();

    // 4: D lock for 40 cycles with C waiting.
    d_req = 1; d_lock = 1; d_addr = 32'h40;
    obs();
    chk("t4_lock_enter", {30'd0, c_gnt, d_gnt}, 1);
    adv();
    c_req = 1; c_addr = 32'h44;
    cg_n = 0; dg_n = 0;
    for (int i = 1; i <= 40; i++) begin
      obs();
      if (c_gnt) begin cg_n++; cg_at.push_back(i); end
      if (d_gnt) dg_n++;
      adv();
    end
    chk("t4_c_grants", cg_n, 2);
    chk("t4_d_grants", dg_n, 38);
    if (cg_n == 2) begin
      chk("t4_c_first", cg_at[0], 17);
      chk("t4_c_second", cg_at[1], 34);
    end
    d_lock = 0; d_req = 0;
    obs();
    chk("t4_unlock_c", {31'd0, c_gnt}, 1);
    adv();
    idle();
    adv();

    // 5: C read out of range.
    c_req = 1; c_addr = MSZ + 4;
    obs();
    chk("t5_gnt", {31'd0, c_gnt}, 1);
    chk("t5_mem_en", {31'd0, mem_en}, 0);
    adv();
    c_req = 0;
    obs();
    chk("t5_rvalid", {31'd0, c_rvalid}, 1);
    chk("t5_err", {31'd0, c_err}, 1);
    chk("t5_rdata", c_rdata, 0);
    adv();

    // 6: reset the cycle after a granted read.
    c_req = 1; c_addr = 32'h10;
    obs();
    chk("t6_gnt", {31'd0, c_gnt}, 1);
    adv();
    idle();
    rstn = 1'b0;
    obs();
    chk("t6_rvalid", {30'd0, c_rvalid, d_rvalid}, 0);
    chk("t6_mem_we", {28'd0, mem_we}, 0);
    adv();
    adv();
    rstn = 1'b1;
    c_req = 1; c_addr = 32'h8;
    d_req = 1; d_addr = 32'hC;
    obs();
    chk("t6_tie_c", {30'd0, c_gnt, d_gnt}, 2);
    adv();
    idle();
    adv();
    obs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
